mem_lane_wr_sched: RTL and testbench
====================================

Name: mem_lane_wr_sched

Overview:
- Write-port scheduler for a dual-port BRAM lane.
- Shares the lane's single write port (ena/wea/addra/dia) between two valid/ready write requesters, A and B.
  - Typical pairing: A = host/UART loader, B = on-chip pattern engine.
- Contains a clear engine that sweeps every lane address with a fill word.
- Read port is untouched; this block lives entirely in the write clock domain.

Parameters:
- ADDR_BITS, 11, lane address width; lane depth = 2**ADDR_BITS.
- DW, 8, lane data width.

Ports:
- clk  input  1  write-domain clock; drives the lane's write clock.
- reset  input  1  asynchronous, active-high reset.
- a_valid  input  1  requester A has a write pending.
- a_ready  output  1  requester A write accepted this cycle.
- a_addr  input  ADDR_BITS  requester A address.
- a_data  input  DW  requester A data.
- b_valid, b_ready, b_addr, b_data  same as the A ports, for requester B.
- clear_start  input  1  single-cycle pulse; starts a full-lane clear.
- clear_value  input  DW  fill word; sampled on the accepted clear_start.
- clear_busy  output  1  clear sweep in progress.
- clear_done  output  1  one-cycle pulse when the sweep finishes.
- lane_ena  output  1  to the lane's ena.
- lane_wea  output  1  to the lane's wea.
- lane_addr  output  ADDR_BITS  to the lane's addra.
- lane_data  output  DW  to the lane's dia.

Behaviour:
- Reset (asynchronous, active-high):
  - All registered outputs go to 0: lane_ena, lane_wea, lane_addr, lane_data, clear_busy, clear_done.
  - State = ARB; last_grant = B, so A wins the first tie.
  - Clear counter = 0; latched fill word = 0.
  - Reset asserted mid-clear abandons the sweep; no clear_done is issued.
- State machine (two states):
  - ARB:
    - Arbitrates A and B.
    - Goes to CLEAR when clear_start=1. That same cycle both readies are 0, clear_value is latched, and the counter is set to 0.
  - CLEAR:
    - Each cycle writes fill word at counter, then increments counter.
    - After issuing address 2**ADDR_BITS-1, returns to ARB and pulses clear_done.
    - clear_done is registered: it is high on the cycle after the last write strobe's issuing cycle, and it coincides with that write appearing on the lane outputs.
    - clear_start while in CLEAR is ignored; no restart.
- Arbitration, in ARB with clear_start=0:
  - Only one valid: that requester gets ready=1.
  - Both valid: grant goes to the requester that is not last_grant (round-robin); the granted requester is stored as last_grant.
  - a_ready and b_ready are combinational from the valids, state and last_grant. They are never both 1.
  - Both are 0 in CLEAR and in the cycle clear_start is seen.
  - A transfer is accepted on valid&&ready at a rising clk.
- Write output timing:
  - Registered; latency 1 cycle from acceptance or from a clear-sweep step.
  - Accepted transfer at edge N: lane_ena=lane_wea=1 with the winner's addr/data during cycle N+1.
  - Cycles with no grant and not clearing: lane_ena=lane_wea=0. lane_addr and lane_data hold their previous values.
- Throughput:
  - One write per cycle, including back-to-back grants to the same requester when the other is idle.
  - Clear takes exactly 2**ADDR_BITS cycles of lane writes.
- Counter: ADDR_BITS wide; the terminal condition is counter all-ones. The counter never wraps past it.
- Requester contract:
  - Requesters hold addr/data stable while valid && !ready.
  - The block does not buffer; it has no internal FIFO.

Optional Feature:
- Macro: MEM_LANE_WR_SCHED_PRIO_A_EN.
- Defined:
  - Fixed priority: A always wins when both are valid; last_grant is unused.
  - B can starve.
  - Clear behaviour is unchanged.
- Undefined (default): round-robin arbitration as described in Behaviour.

Test Plan:
- Reset during idle, then release with only a_valid, a_addr=0x005, a_data=0x3C → a_ready=1 in the first cycle; next cycle lane_ena=lane_wea=1, lane_addr=0x005, lane_data=0x3C.
- a_valid and b_valid held high for 6 cycles, addresses 0x100.. (A) and 0x200.. (B) → grants alternate A,B,A,B,A,B; lane_addr sequence 0x100,0x200,0x101,0x201,0x102,0x202. With MEM_LANE_WR_SCHED_PRIO_A_EN: 0x100..0x105, and b_ready stays 0.
- clear_start pulse with clear_value=0xA5, ADDR_BITS=4 → clear_busy high 16 cycles; lane_addr 0..15 with lane_data=0xA5 every cycle; clear_done single pulse aligned with the addr 15 write; a_valid held high meanwhile gets a_ready=0 until ARB returns, then is accepted first.
- Second clear_start issued at sweep address 7 → ignored: sweep completes 0..15 once, exactly one clear_done.
- reset asserted at sweep address 9, released 3 cycles later → outputs 0 immediately (asynchronous); no clear_done; state is ARB; a subsequent b_valid is granted on the first post-reset cycle.
- a_valid high with a_ready=0 during clear, a_addr/a_data held stable → after clear_done, exactly one write of the held values; no duplicate, no drop.

Source files
------------

// File: rtl/mem_lane_wr_sched.sv
// Write-port scheduler for one dual-port BRAM lane: arbitrates two write requesters and runs a full-lane clear sweep.
// Define MEM_LANE_WR_SCHED_PRIO_A_EN for fixed A-over-B priority instead of round-robin.
module mem_lane_wr_sched #(
  parameter int ADDR_BITS = 11,
  parameter int DW        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [DW-1:0]        a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [DW-1:0]        b_data,
  input  logic                 clear_start,
  input  logic [DW-1:0]        clear_value,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic                 lane_ena,
  output logic                 lane_wea,
  output logic [ADDR_BITS-1:0] lane_addr,
  output logic [DW-1:0]        lane_data
);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] clr_cnt;
  logic [DW-1:0]        fill;
  logic                 arb_open;
  logic                 pick_a;
  logic                 pick_b;

`ifndef MEM_LANE_WR_SCHED_PRIO_A_EN
  typedef enum logic {GRANT_A, GRANT_B} grant_t;
  grant_t last_grant;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    arb_open = (state == ARB) && !clear_start;
`ifdef MEM_LANE_WR_SCHED_PRIO_A_EN
    pick_a   = a_valid;
`else
    pick_a   = a_valid && (!b_valid || (last_grant == GRANT_B));
`endif
    pick_b   = b_valid && !pick_a;
  end

  assign a_ready = arb_open && pick_a;
  assign b_ready = arb_open && pick_b;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
`ifndef MEM_LANE_WR_SCHED_PRIO_A_EN
      last_grant <= GRANT_B;
`endif
      clr_cnt    <= '0;
      fill       <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      lane_ena   <= 1'b0;
      lane_wea   <= 1'b0;
      lane_addr  <= '0;
      lane_data  <= '0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        ARB: begin
          if (clear_start) begin
            state      <= CLEAR;
            fill       <= clear_value;
            clr_cnt    <= '0;
            clear_busy <= 1'b1;
            lane_ena   <= 1'b0;
            lane_wea   <= 1'b0;
          end else if (a_ready) begin
            lane_ena   <= 1'b1;
            lane_wea   <= 1'b1;
            lane_addr  <= a_addr;
            lane_data  <= a_data;
`ifndef MEM_LANE_WR_SCHED_PRIO_A_EN
            last_grant <= GRANT_A;
`endif
          end else if (b_ready) begin
            lane_ena   <= 1'b1;
            lane_wea   <= 1'b1;
            lane_addr  <= b_addr;
            lane_data  <= b_data;
`ifndef MEM_LANE_WR_SCHED_PRIO_A_EN
            last_grant <= GRANT_B;
`endif
          end else begin
            // Idle cycle: strobes drop, address and data hold their last values.
            lane_ena   <= 1'b0;
            lane_wea   <= 1'b0;
          end
        end
        CLEAR: begin
          lane_ena  <= 1'b1;
          lane_wea  <= 1'b1;
          lane_addr <= clr_cnt;
          lane_data <= fill;
          if (&clr_cnt) begin
            // Last address issued: done lands together with this final write on the lane.
            state      <= ARB;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lane_wr_sched.sv
// Self-checking bench for mem_lane_wr_sched: directed scenarios plus random traffic against a queue-based write model.
module tb_mem_lane_wr_sched;
  localparam int AB    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0, clear_start = 1'b0;
  logic [AB-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0, clear_value = '0;
  logic          a_ready, b_ready, clear_busy, clear_done, lane_ena, lane_wea;
  logic [AB-1:0] lane_addr;
  logic [DW-1:0] lane_data;

  mem_lane_wr_sched #(.ADDR_BITS(AB), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .clear_start(clear_start), .clear_value(clear_value),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .lane_ena(lane_ena), .lane_wea(lane_wea), .lane_addr(lane_addr), .lane_data(lane_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending clear writes are a queue; a grant becomes one expected lane write.
  typedef struct {
    logic [AB-1:0] addr;
    logic [DW-1:0] data;
    bit            last;
  } wr_t;
  wr_t           clr_q[$];
  bit            m_clearing;
  bit            m_last_b;
  logic          exp_ena, exp_busy, exp_done;
  logic [AB-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  logic          obs_ena, obs_busy, obs_done;
  logic [AB-1:0] obs_addr;
  logic [DW-1:0] obs_data;
  logic          got_ar, got_br;

  task automatic model_reset();
    clr_q.delete();
    m_clearing = 0;
    m_last_b   = 1;
    exp_ena = 0; exp_busy = 0; exp_done = 0; exp_addr = '0; exp_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_valid = 0; b_valid = 0; clear_start = 0;
    #1;
    checks++;
    if (lane_ena !== 1'b0 || lane_wea !== 1'b0 || lane_addr !== '0 || lane_data !== '0 ||
        clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ena=%b wea=%b addr=%0h data=%0h busy=%b done=%b expected all 0",
               lane_ena, lane_wea, lane_addr, lane_data, clear_busy, clear_done);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle, entered and left at a falling edge: check outputs, drive, check readies, advance model.
  task automatic drive_cycle(input bit av, input logic [AB-1:0] aa, input logic [DW-1:0] ad,
                             input bit bv, input logic [AB-1:0] ba, input logic [DW-1:0] bd,
                             input bit cs, input logic [DW-1:0] cv);
    bit ea, eb;
    wr_t w;
    obs_ena = lane_ena; obs_busy = clear_busy; obs_done = clear_done;
    obs_addr = lane_addr; obs_data = lane_data;
    checks += 6;
    if (lane_ena !== exp_ena) begin errors++; $display("FAIL lane_ena: got %b expected %b", lane_ena, exp_ena); end
    if (lane_wea !== exp_ena) begin errors++; $display("FAIL lane_wea: got %b expected %b", lane_wea, exp_ena); end
    if (lane_addr !== exp_addr) begin errors++; $display("FAIL lane_addr: got %0h expected %0h", lane_addr, exp_addr); end
    if (lane_data !== exp_data) begin errors++; $display("FAIL lane_data: got %0h expected %0h", lane_data, exp_data); end
    if (clear_busy !== exp_busy) begin errors++; $display("FAIL clear_busy: got %b expected %b", clear_busy, exp_busy); end
    if (clear_done !== exp_done) begin errors++; $display("FAIL clear_done: got %b expected %b", clear_done, exp_done); end

    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    clear_start = cs; clear_value = cv;
    #1;
`ifdef MEM_LANE_WR_SCHED_PRIO_A_EN
    ea = !m_clearing && !cs && av;
`else
    ea = !m_clearing && !cs && av && (!bv || m_last_b);
`endif
    eb = !m_clearing && !cs && bv && !ea;
    got_ar = a_ready; got_br = b_ready;
    checks += 2;
    if (a_ready !== ea) begin errors++; $display("FAIL a_ready: got %b expected %b", a_ready, ea); end
    if (b_ready !== eb) begin errors++; $display("FAIL b_ready: got %b expected %b", b_ready, eb); end

    @(posedge clk);
    exp_done = 0;
    if (m_clearing) begin
      w = clr_q.pop_front();
      exp_ena = 1; exp_addr = w.addr; exp_data = w.data; exp_done = w.last;
      if (w.last) begin m_clearing = 0; exp_busy = 0; end
    end else if (cs) begin
      for (int i = 0; i < DEPTH; i++) begin
        w.addr = AB'(i); w.data = cv; w.last = (i == DEPTH - 1);
        clr_q.push_back(w);
      end
      m_clearing = 1; exp_busy = 1; exp_ena = 0;
    end else if (ea) begin
      exp_ena = 1; exp_addr = aa; exp_data = ad; m_last_b = 0;
    end else if (eb) begin
      exp_ena = 1; exp_addr = ba; exp_data = bd; m_last_b = 1;
    end else begin
      exp_ena = 0;
    end
    @(negedge clk);
    clear_start = 0;
  endtask

  task automatic idle_cycle();
    drive_cycle(0, '0, '0, 0, '0, '0, 0, '0);
  endtask

  task automatic test_reset();
    do_reset();
    drive_cycle(1, 4'h5, 8'h3C, 0, '0, '0, 0, '0);
    checks++;
    if (got_ar !== 1'b1) begin errors++; $display("FAIL first_grant: got a_ready=%b expected 1", got_ar); end
    a_valid = 0;
    idle_cycle();
    checks++;
    if (obs_ena !== 1'b1 || obs_addr !== 4'h5 || obs_data !== 8'h3C) begin
      errors++;
      $display("FAIL first_write: got ena=%b addr=%0h data=%0h expected 1/5/3c", obs_ena, obs_addr, obs_data);
    end
  endtask

  task automatic test_round_robin();
    int ia = 0, ib = 0;
    logic [AB-1:0] want;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c < 6) drive_cycle(1, AB'(ia), 8'h10 + DW'(ia), 1, AB'(8 + ib), 8'h80 + DW'(ib), 0, '0);
      else idle_cycle();
      if (c < 6) begin
        if (got_ar) ia++;
        if (got_br) ib++;
      end
      if (c >= 1) begin
`ifdef MEM_LANE_WR_SCHED_PRIO_A_EN
        want = AB'(c - 1);
`else
        want = ((c - 1) % 2 == 0) ? AB'((c - 1) / 2) : AB'(8 + (c - 1) / 2);
`endif
        checks++;
        if (obs_ena !== 1'b1 || obs_addr !== want) begin
          errors++;
          $display("FAIL rr_sequence[%0d]: got ena=%b addr=%0h expected 1/%0h", c - 1, obs_ena, obs_addr, want);
        end
      end
    end
  endtask

  task automatic test_clear_with_held_a();
    int busy_cnt = 0, done_cnt = 0, clr_wr = 0, held_wr = 0, acc_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (c == 0) drive_cycle(1, 4'h3, 8'h5A, 0, '0, '0, 1, 8'hA5);
      else if (acc_at < 0) drive_cycle(1, 4'h3, 8'h5A, 0, '0, '0, 0, '0);
      else idle_cycle();
      if (obs_busy) busy_cnt++;
      if (obs_ena && obs_data == 8'hA5) clr_wr++;
      if (obs_ena && obs_addr == 4'h3 && obs_data == 8'h5A) held_wr++;
      if (obs_done) begin
        done_cnt++;
        checks++;
        if (obs_addr !== AB'(DEPTH - 1) || obs_data !== 8'hA5) begin
          errors++;
          $display("FAIL done_alignment: got addr=%0h data=%0h expected %0h/a5", obs_addr, obs_data, DEPTH - 1);
        end
      end
      if (acc_at < 0 && got_ar) acc_at = c;
      if (acc_at >= 0 && c >= acc_at + 3) break;
    end
    a_valid = 0;
    checks += 5;
    if (busy_cnt != DEPTH) begin errors++; $display("FAIL busy_cycles: got %0d expected %0d", busy_cnt, DEPTH); end
    if (done_cnt != 1) begin errors++; $display("FAIL done_pulses: got %0d expected 1", done_cnt); end
    if (clr_wr != DEPTH) begin errors++; $display("FAIL clear_writes: got %0d expected %0d", clr_wr, DEPTH); end
    if (acc_at != DEPTH + 1) begin errors++; $display("FAIL held_accept_cycle: got %0d expected %0d", acc_at, DEPTH + 1); end
    if (held_wr != 1) begin errors++; $display("FAIL held_writes: got %0d expected 1", held_wr); end
  endtask

  task automatic test_clear_restart();
    int done_cnt = 0, clr_wr = 0, bad_wr = 0;
    bit fired = 0;
    bit cs;
    drive_cycle(0, '0, '0, 0, '0, '0, 1, 8'h3C);
    for (int c = 0; c < 30; c++) begin
      cs = !fired && clear_busy && lane_ena && lane_addr == 4'h7;
      if (cs) fired = 1;
      drive_cycle(0, '0, '0, 0, '0, '0, cs, 8'hFF);
      if (obs_ena && obs_data == 8'h3C) clr_wr++;
      if (obs_ena && obs_data == 8'hFF) bad_wr++;
      if (obs_done) done_cnt++;
    end
    checks += 4;
    if (!fired) begin errors++; $display("FAIL restart_point: got no sweep at address 7 expected one"); end
    if (done_cnt != 1) begin errors++; $display("FAIL restart_done: got %0d expected 1", done_cnt); end
    if (clr_wr != DEPTH) begin errors++; $display("FAIL restart_writes: got %0d expected %0d", clr_wr, DEPTH); end
    if (bad_wr != 0) begin errors++; $display("FAIL restart_fill: got %0d writes of ff expected 0", bad_wr); end
  endtask

  task automatic test_reset_mid_clear();
    bit hit = 0;
    int done_cnt = 0, b_wr = 0;
    drive_cycle(0, '0, '0, 0, '0, '0, 1, 8'h99);
    for (int c = 0; c < 30 && !hit; c++) begin
      if (lane_ena && clear_busy && lane_addr == 4'h9) hit = 1;
      else idle_cycle();
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL sweep_reach_9: got timeout expected sweep at address 9"); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (lane_ena !== 1'b0 || lane_addr !== '0 || lane_data !== '0 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got ena=%b addr=%0h data=%0h busy=%b done=%b expected all 0",
               lane_ena, lane_addr, lane_data, clear_busy, clear_done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (clear_done) done_cnt++;
    end
    reset = 1'b0;
    model_reset();
    drive_cycle(0, '0, '0, 1, 4'h4, 8'h42, 0, '0);
    checks++;
    if (got_br !== 1'b1) begin errors++; $display("FAIL post_reset_b_grant: got b_ready=%b expected 1", got_br); end
    for (int c = 0; c < 20; c++) begin
      idle_cycle();
      if (obs_done) done_cnt++;
      if (obs_ena && obs_addr == 4'h4 && obs_data == 8'h42) b_wr++;
    end
    checks += 2;
    if (done_cnt != 0) begin errors++; $display("FAIL abandoned_done: got %0d expected 0", done_cnt); end
    if (b_wr != 1) begin errors++; $display("FAIL post_reset_b_write: got %0d expected 1", b_wr); end
  endtask

  task automatic test_random();
    bit av = 0, bv = 0, cs;
    logic [AB-1:0] aa = '0, ba = '0;
    logic [DW-1:0] ad = '0, bd = '0;
    for (int c = 0; c < 600; c++) begin
      cs = ($urandom_range(0, 39) == 0);
      drive_cycle(av, aa, ad, bv, ba, bd, cs, DW'($urandom));
      // Requesters only change their request once the current one is taken or was never raised.
      if (!av || got_ar) begin av = ($urandom_range(0, 2) != 0); aa = AB'($urandom); ad = DW'($urandom); end
      if (!bv || got_br) begin bv = ($urandom_range(0, 2) != 0); ba = AB'($urandom); bd = DW'($urandom); end
    end
    for (int c = 0; c < DEPTH + 2; c++) idle_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_clear_with_held_a();
    test_clear_restart();
    test_reset_mid_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
